// File: rtl/sop_pipe_pkg.sv
// Shared definitions for the scannable two-level logic pipeline.
// Mode encodings and scan chain sizing.
package sop_pipe_pkg;

  localparam logic [1:0] MODE_SOP = 2'b00;
  localparam logic [1:0] MODE_AOI = 2'b01;
  localparam logic [1:0] MODE_POS = 2'b10;
  localparam logic [1:0] MODE_OAI = 2'b11;

  function automatic int chain_len(
    input int stages,
    input int channels
  );
    return stages * (channels + 1);
  endfunction

endpackage

// File: rtl/sop_channel.sv
// One channel: TERMS x TERM_WIDTH two-level reduction.
// Mode picks AND-OR, AOI, OR-AND or OAI.
module sop_channel
  import sop_pipe_pkg::*;
#(
  parameter int TERMS      = 2,
  parameter int TERM_WIDTH = 2
) (
  input  logic [1:0]                  mode,
  input  logic [TERMS*TERM_WIDTH-1:0] terms,
  output logic                        y
);

  logic w_sop;
  logic w_pos;

  always_comb begin
    w_sop = 1'b0;
    w_pos = 1'b1;
    for (int t = 0; t < TERMS; t++) begin
      w_sop = w_sop | (&terms[t*TERM_WIDTH +: TERM_WIDTH]);
      w_pos = w_pos & (|terms[t*TERM_WIDTH +: TERM_WIDTH]);
    end
  end

  always_comb begin
    y = w_sop;
    unique case (mode)
      MODE_SOP: y = w_sop;
      MODE_AOI: y = ~w_sop;
      MODE_POS: y = w_pos;
      MODE_OAI: y = ~w_pos;
      default:  y = w_sop;
    endcase
  end

endmodule

// File: rtl/sop_pipe_scan.sv
// Multi-channel programmable logic cell, STAGES-deep pipeline.
// All pipeline flops form one flat register that doubles as the scan chain.
module sop_pipe_scan
  import sop_pipe_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int TERMS      = 2,
  parameter int TERM_WIDTH = 2,
  parameter int STAGES     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [1:0]                         mode,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CHANNELS*TERMS*TERM_WIDTH-1:0] in_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHANNELS-1:0]                out_data,
  input  logic                               scan_en,
  input  logic                               scan_in,
  output logic                               scan_out
);

  localparam int TW = TERMS * TERM_WIDTH;
  localparam int SW = CHANNELS + 1;
  localparam int L  = chain_len(STAGES, CHANNELS);
  localparam int OB = (STAGES - 1) * SW;

  // Stage s occupies [s*SW +: SW]: bit 0 valid, bits 1.. data.
  logic [L-1:0]        r_chain;
  logic [L-1:0]        w_next;
  logic [CHANNELS-1:0] w_f;
  logic                w_adv;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    sop_channel #(
      .TERMS      (TERMS),
      .TERM_WIDTH (TERM_WIDTH)
    ) u_ch (
      .mode  (mode),
      .terms (in_data[c*TW +: TW]),
      .y     (w_f[c])
    );
  end

  assign w_adv = !scan_en && !(out_valid && !out_ready);

  always_comb begin
    w_next = r_chain;
    w_next[0 +: SW] = {w_f, in_valid};
    for (int s = 1; s < STAGES; s++) begin
      w_next[s*SW +: SW] = r_chain[(s-1)*SW +: SW];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chain <= '0;
    end else if (scan_en) begin
      r_chain <= {r_chain[L-2:0], scan_in};
    end else if (w_adv) begin
      r_chain <= w_next;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_chain[OB];
  assign out_data  = r_chain[OB+1 +: CHANNELS];
  assign scan_out  = r_chain[L-1];

endmodule

// File: tb/tb_sop_pipe_scan.sv
// Self-checking bench for sop_pipe_scan.
// Directed spec cases plus randomized traffic against a slot model.
module tb_sop_pipe_scan;

  localparam int CH = 4;
  localparam int T  = 2;
  localparam int TW = 2;
  localparam int ST = 2;
  localparam int IW = CH * T * TW;
  localparam int L  = ST * (CH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    mode = 2'b00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [CH-1:0] out_data;
  logic          scan_en = 1'b0;
  logic          scan_in = 1'b0;
  logic          scan_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sop_pipe_scan #(
    .CHANNELS   (CH),
    .TERMS      (T),
    .TERM_WIDTH (TW),
    .STAGES     (ST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .scan_en   (scan_en),
    .scan_in   (scan_in),
    .scan_out  (scan_out)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    scan_en   = 1'b0;
    scan_in   = 1'b0;
    out_ready = 1'b1;
    mode      = 2'b00;
    in_data   = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  function automatic logic [CH-1:0] ref_f(input logic [IW-1:0] d,
                                          input logic [1:0] m);
    logic [CH-1:0] r;
    int mask, v, sop, pos;
    mask = (1 << TW) - 1;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      sop = 0;
      pos = 1;
      for (int t = 0; t < T; t++) begin
        v = int'(d >> ((c * T + t) * TW)) & mask;
        if (v == mask) sop = 1;
        if (v == 0) pos = 0;
      end
      case (m)
        2'd0: r[c] = (sop != 0);
        2'd1: r[c] = (sop == 0);
        2'd2: r[c] = (pos != 0);
        default: r[c] = (pos == 0);
      endcase
    end
    return r;
  endfunction

  task automatic send_dir(input string tag, input logic [IW-1:0] d,
                          input logic [1:0] m, input logic [CH-1:0] exp);
    in_data   = d;
    mode      = m;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk({tag, ".rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk({tag, ".v1"}, out_valid, 0);
    tick();
    chk({tag, ".v2"}, out_valid, 1);
    chk({tag, ".d"}, out_data, exp);
    tick();
    chk({tag, ".v3"}, out_valid, 0);
  endtask

  bit            mv[$];
  logic [CH-1:0] md[$];
  logic [CH-1:0] held;
  bit            stalled;
  bit            adv;
  logic [L-1:0]  pat;

  initial begin
    do_reset();
    chk("rst.ov", out_valid, 0);
    chk("rst.od", out_data, 0);
    chk("rst.so", scan_out, 0);
    chk("rst.rdy", in_ready, 1);

    send_dir("sop03", 16'h0003, 2'b00, 4'b0001);
    send_dir("aoi03", 16'h0003, 2'b01, 4'b1110);
    send_dir("pos0f", 16'h000F, 2'b10, 4'b0001);
    send_dir("oaiff", 16'hFFFF, 2'b11, 4'b0000);
    send_dir("aoi00", 16'h0000, 2'b01, 4'b1111);

    // back-to-back beats under backpressure
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0003;
    mode      = 2'b00;
    tick();
    in_data = 16'h0000;
    mode    = 2'b01;
    tick();
    in_valid = 1'b0;
    chk("bp.ov", out_valid, 1);
    chk("bp.rdy", in_ready, 0);
    chk("bp.a", out_data, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp.hold", out_data, 4'b0001);
      chk("bp.holdv", out_valid, 1);
      chk("bp.holdr", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp.bv", out_valid, 1);
    chk("bp.b", out_data, 4'b1111);
    tick();
    chk("bp.end", out_valid, 0);

    // single one walked through the chain after reset
    do_reset();
    scan_en = 1'b1;
    scan_in = 1'b1;
    #1;
    chk("sc.rdy0", in_ready, 0);
    for (int e = 1; e <= 14; e++) begin
      tick();
      scan_in = 1'b0;
      chk("sc.so", scan_out, (e == L) ? 1 : 0);
      chk("sc.rdy", in_ready, 0);
    end

    // capture a beat then unload the output stage
    do_reset();
    in_data  = 16'h0003;
    mode     = 2'b00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("cap.ov", out_valid, 1);
    scan_en = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("cap.so0", scan_out, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("cap.so", scan_out, (k >= 3) ? 1 : 0);
    end
    in_valid = 1'b0;

    // load a valid output stage by scan, then resume
    pat = '0;
    pat[5] = 1'b1;
    pat[7] = 1'b1;
    pat[9] = 1'b1;
    for (int i = L - 1; i >= 0; i--) begin
      scan_in = pat[i];
      tick();
    end
    scan_en = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("ld.ov", out_valid, 1);
    chk("ld.od", out_data, 4'b1010);
    chk("ld.rdy", in_ready, 0);
    out_ready = 1'b1;
    tick();
    chk("ld.drain", out_valid, 0);

    // asynchronous reset while holding a result
    do_reset();
    in_data  = 16'hFFFF;
    mode     = 2'b00;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("ar.pre", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("ar.ov", out_valid, 0);
    chk("ar.od", out_data, 0);
    chk("ar.so", scan_out, 0);
    tick();
    rst = 1'b0;
    #1;
    send_dir("ar.nx", 16'h0003, 2'b01, 4'b1110);

    // random traffic against a slot-queue model
    do_reset();
    for (int s = 0; s < ST; s++) begin
      mv.push_back(1'b0);
      md.push_back('0);
    end
    stalled = 1'b0;
    held = '0;
    for (int i = 0; i < 800; i++) begin
      if (i < 780) begin
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = IW'($urandom);
        mode      = 2'($urandom_range(0, 3));
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      chk("rnd.ov", out_valid, mv[0]);
      if (mv[0]) chk("rnd.od", out_data, md[0]);
      if (stalled) chk("rnd.hold", out_data, held);
      adv = !(mv[0] && !out_ready);
      chk("rnd.rdy", in_ready, adv);
      stalled = mv[0] && !out_ready;
      held = md[0];
      if (adv) begin
        void'(mv.pop_front());
        void'(md.pop_front());
        mv.push_back(in_valid);
        md.push_back(ref_f(in_data, mode));
      end
      tick();
    end
    chk("rnd.empty", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
